// File: rtl/led_reg_pkg.sv
// ---------------------------------------------------------------------------
// led_reg_pkg
// Shared definitions for the LED register-file controller:
//   - I2C sub-address map constants
//   - CTRL register bit positions
//   - commit state machine encoding
// ---------------------------------------------------------------------------
package led_reg_pkg;

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_STATUS      = 8'h01;
    localparam logic [7:0] ADDR_COMMIT      = 8'h02;
    localparam logic [7:0] ADDR_ENABLE      = 8'h03;
    localparam logic [7:0] ADDR_PRESCALE    = 8'h04;
    localparam logic [7:0] ADDR_ACTIVE_EN   = 8'h05;
    localparam logic [7:0] ADDR_DUTY_BASE   = 8'h10;
    localparam logic [7:0] ADDR_ACTIVE_BASE = 8'h20;

    localparam int CTRL_GLOBAL_EN_BIT = 0;
    localparam int CTRL_SYNC_BIT      = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } commit_state_e;

endpackage

// File: rtl/led_commit_fsm.sv
// ---------------------------------------------------------------------------
// led_commit_fsm
// Sequences the shadow-to-active transfer of the LED duty registers.
//   clk, rst_n   : clock, asynchronous active-low reset
//   commit_req   : a COMMIT register write this cycle
//   sync         : CTRL.sync; when set the copy waits for period_wrap
//   period_wrap  : PWM period boundary pulse
//   copy         : high for the single COPY cycle (registered)
//   busy         : high while a commit waits for period_wrap (registered)
// ---------------------------------------------------------------------------
module led_commit_fsm
    import led_reg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic commit_req,
    input  logic sync,
    input  logic period_wrap,
    output logic copy,
    output logic busy
);

    commit_state_e state_q, state_d;
    logic          copy_q, busy_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (commit_req) state_d = sync ? ST_ARMED : ST_COPY;
            // Extra COMMIT writes are absorbed here; dropping sync releases
            // the pending commit without waiting for a wrap.
            ST_ARMED: if (period_wrap || !sync) state_d = ST_COPY;
            // A request landing in the COPY cycle is re-queued, not lost.
            ST_COPY:  begin
                if (commit_req) state_d = sync ? ST_ARMED : ST_COPY;
                else            state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state value so they line up
    // exactly with state_q without any decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            copy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            copy_q  <= (state_d == ST_COPY);
            busy_q  <= (state_d == ST_ARMED);
        end
    end

    assign copy = copy_q;
    assign busy = busy_q;

endmodule

// File: rtl/led_reg_ctrl.sv
// ---------------------------------------------------------------------------
// led_reg_ctrl
// Register file between the i2c_slave application bus and the PWM channel
// engines. Holds double-buffered per-channel duty registers and an enable
// mask; a commit moves shadow values to the active set in one cycle,
// optionally aligned to a PWM period boundary.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rw, addr           transaction direction / current sub-address
//   wen, wdata         one-cycle write strobe and data
//   rdata_used         read data has just been captured (clears STATUS.done)
//   rdata              registered read data for addr
//   period_wrap        PWM period-end pulse
//   duty               active duties, channel n at [8n+7:8n]
//   ch_en              active channel-enable mask
//   global_en          CTRL.bit0
//   prescale           PRESCALE register
//   commit_busy        a commit is waiting for period_wrap
//
// Build option:
//   LED_REG_ACTIVE_READBACK_EN  when defined, 0x20+n reads active duty n and
//                               0x05 reads the active enable mask.
//
// The ENABLE register is 8 bits wide, so channels 8..15 (NUM_CH > 8) have no
// enable bit and stay disabled.
// ---------------------------------------------------------------------------
module led_reg_ctrl
    import led_reg_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rw,
    input  logic [7:0]          addr,
    input  logic                wen,
    input  logic [7:0]          wdata,
    input  logic                rdata_used,
    output logic [7:0]          rdata,
    input  logic                period_wrap,
    output logic [8*NUM_CH-1:0] duty,
    output logic [NUM_CH-1:0]   ch_en,
    output logic                global_en,
    output logic [7:0]          prescale,
    output logic                commit_busy
);

    // ENABLE bits at or above NUM_CH are not stored and read back as 0.
    localparam logic [7:0] EN_MASK =
        (NUM_CH >= 8) ? 8'hFF : 8'((16'd1 << NUM_CH) - 16'd1);

    logic [1:0]              ctrl_q, ctrl_d;
    logic [7:0]              prescale_q, prescale_d;
    logic [7:0]              en_sh_q, en_sh_d;
    logic                    done_q, done_d;
    logic [NUM_CH-1:0][7:0]  duty_sh_q, duty_sh_d;
    logic [NUM_CH-1:0][7:0]  duty_act_q, duty_act_d;
    logic [NUM_CH-1:0]       ch_en_q, ch_en_d;
    logic [7:0]              rdata_q, rdata_d;

    logic                    commit_req;
    logic                    copy;
    logic                    busy;
    logic                    status_clr;
    logic [NUM_CH-1:0]       en_sh_wide;

    assign commit_req = wen && (addr == ADDR_COMMIT);
    assign status_clr = rdata_used && rw && (addr == ADDR_STATUS);

    led_commit_fsm u_commit_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_req  (commit_req),
        .sync        (ctrl_q[CTRL_SYNC_BIT]),
        .period_wrap (period_wrap),
        .copy        (copy),
        .busy        (busy)
    );

    // Shadow ENABLE resized to the channel count.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_en_wide
        if (g < 8) begin : g_bit
            assign en_sh_wide[g] = en_sh_q[g];
        end else begin : g_zero
            assign en_sh_wide[g] = 1'b0;
        end
    end

    // ---------------- register writes ----------------
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        en_sh_d    = en_sh_q;
        duty_sh_d  = duty_sh_q;
        if (wen) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d[CTRL_GLOBAL_EN_BIT] = wdata[CTRL_GLOBAL_EN_BIT];
                    ctrl_d[CTRL_SYNC_BIT]      = wdata[CTRL_SYNC_BIT];
                end
                ADDR_ENABLE:   en_sh_d    = wdata & EN_MASK;
                ADDR_PRESCALE: prescale_d = wdata;
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (addr == ADDR_DUTY_BASE + 8'(n)) duty_sh_d[n] = wdata;
            end
        end
    end

    // ---------------- commit transfer / status ----------------
    // The copy samples the shadow flops, so a shadow write in the COPY cycle
    // lands in shadow only and waits for the next commit.
    always_comb begin
        duty_act_d = copy ? duty_sh_q  : duty_act_q;
        ch_en_d    = copy ? en_sh_wide : ch_en_q;
        // A copy in the same cycle as a read-clear keeps done set.
        if (copy)            done_d = 1'b1;
        else if (status_clr) done_d = 1'b0;
        else                 done_d = done_q;
    end

    // ---------------- read mux ----------------
`ifdef LED_REG_ACTIVE_READBACK_EN
    logic [7:0] ch_en_rd;
    for (genvar g = 0; g < 8; g++) begin : g_en_rd
        if (g < NUM_CH) begin : g_bit
            assign ch_en_rd[g] = ch_en_q[g];
        end else begin : g_zero
            assign ch_en_rd[g] = 1'b0;
        end
    end
`endif

    always_comb begin
        rdata_d = 8'h00;
        case (addr)
            ADDR_CTRL:     rdata_d = {6'b0, ctrl_q};
            ADDR_STATUS:   rdata_d = {6'b0, done_q, busy};
            ADDR_ENABLE:   rdata_d = en_sh_q;
            ADDR_PRESCALE: rdata_d = prescale_q;
`ifdef LED_REG_ACTIVE_READBACK_EN
            ADDR_ACTIVE_EN: rdata_d = ch_en_rd;
`endif
            default: ;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr == ADDR_DUTY_BASE + 8'(n)) rdata_d = duty_sh_q[n];
`ifdef LED_REG_ACTIVE_READBACK_EN
            if (addr == ADDR_ACTIVE_BASE + 8'(n)) rdata_d = duty_act_q[n];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            en_sh_q    <= '0;
            done_q     <= 1'b0;
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            ch_en_q    <= '0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            en_sh_q    <= en_sh_d;
            done_q     <= done_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            ch_en_q    <= ch_en_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata       = rdata_q;
    assign duty        = duty_act_q;
    assign ch_en       = ch_en_q;
    assign global_en   = ctrl_q[CTRL_GLOBAL_EN_BIT];
    assign prescale    = prescale_q;
    assign commit_busy = busy;

endmodule

// File: tb/tb_led_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_reg_ctrl
// Directed scenarios followed by random traffic, all compared cycle by cycle
// against a register-level reference model of the controller.
// ---------------------------------------------------------------------------
module tb_led_reg_ctrl;

    localparam int NUM_CH = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rw = 1'b0;
    logic [7:0]          addr = 8'h00;
    logic                wen = 1'b0;
    logic [7:0]          wdata = 8'h00;
    logic                rdata_used = 1'b0;
    logic                period_wrap = 1'b0;
    logic [7:0]          rdata;
    logic [8*NUM_CH-1:0] duty;
    logic [NUM_CH-1:0]   ch_en;
    logic                global_en;
    logic [7:0]          prescale;
    logic                commit_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_reg_ctrl #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rw          (rw),
        .addr        (addr),
        .wen         (wen),
        .wdata       (wdata),
        .rdata_used  (rdata_used),
        .rdata       (rdata),
        .period_wrap (period_wrap),
        .duty        (duty),
        .ch_en       (ch_en),
        .global_en   (global_en),
        .prescale    (prescale),
        .commit_busy (commit_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_sh  [NUM_CH];
    logic [7:0] m_act [NUM_CH];
    logic [7:0] m_en, m_chen, m_presc, m_rdata;
    logic [1:0] m_ctrl;
    bit         m_done, m_pending, m_copy_next;

    task automatic m_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            m_sh[n]  = 8'h00;
            m_act[n] = 8'h00;
        end
        m_en = 0; m_chen = 0; m_presc = 0; m_rdata = 0; m_ctrl = 0;
        m_done = 0; m_pending = 0; m_copy_next = 0;
    endtask

    function automatic logic [7:0] m_map(input logic [7:0] a);
        int ai = int'(a);
        if (ai == 0) return {6'b0, m_ctrl};
        if (ai == 1) return {6'b0, m_done, m_pending};
        if (ai == 3) return m_en;
        if (ai == 4) return m_presc;
        if (ai >= 16 && ai < 16 + NUM_CH) return m_sh[ai - 16];
`ifdef LED_REG_ACTIVE_READBACK_EN
        if (ai == 5) return m_chen;
        if (ai >= 32 && ai < 32 + NUM_CH) return m_act[ai - 32];
`endif
        return 8'h00;
    endfunction

    // One clock edge: everything on the right-hand side is pre-edge state.
    task automatic m_edge();
        bit req, sync, was_copy;
        int ai;
        ai       = int'(addr);
        m_rdata  = m_map(addr);
        sync     = m_ctrl[1];
        req      = wen && (ai == 2);
        was_copy = m_copy_next;
        if (was_copy) begin
            for (int n = 0; n < NUM_CH; n++) m_act[n] = m_sh[n];
            m_chen = m_en;
            m_done = 1;
        end else if (rdata_used && rw && ai == 1) begin
            m_done = 0;
        end
        if (m_pending) begin
            m_copy_next = period_wrap || !sync;
            m_pending   = !m_copy_next;
        end else if (req) begin
            m_pending   = sync;
            m_copy_next = !sync;
        end else begin
            m_pending   = 0;
            m_copy_next = 0;
        end
        if (wen) begin
            if (ai == 0) m_ctrl = wdata[1:0];
            if (ai == 3) m_en = (NUM_CH >= 8) ? wdata : (wdata & 8'((1 << NUM_CH) - 1));
            if (ai == 4) m_presc = wdata;
            if (ai >= 16 && ai < 16 + NUM_CH) m_sh[ai - 16] = wdata;
        end
    endtask

    task automatic m_check();
        for (int n = 0; n < NUM_CH; n++)
            chk($sformatf("duty%0d", n), 32'(duty[8*n +: 8]), 32'(m_act[n]));
        chk("ch_en", 32'(ch_en), 32'(m_chen[NUM_CH-1:0]));
        chk("global_en", 32'(global_en), 32'(m_ctrl[0]));
        chk("prescale", 32'(prescale), 32'(m_presc));
        chk("busy", 32'(commit_busy), 32'(m_pending));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    // Drive one cycle from a negedge, update model on the posedge, check after.
    task automatic cyc(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit r, input bit ru, input bit pw);
        wen = w; addr = a; wdata = d; rw = r; rdata_used = ru; period_wrap = pw;
        @(posedge clk);
        m_edge();
        #1;
        m_check();
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b1, a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic [7:0] a);
        cyc(1'b0, a, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] ra, rd;
        bit rwen, rrw, rru, rpw;

        m_reset();
        @(negedge clk);
        @(negedge clk);
        m_check();
        rst_n = 1'b1;
        @(negedge clk);

        // sync=0 commit
        wr(8'h10, 8'h80);
        wr(8'h11, 8'h40);
        wr(8'h03, 8'h03);
        wr(8'h02, 8'h01);
        idle(8'h01);
        chk("s0_duty0", 32'(duty[7:0]), 32'h80);
        chk("s0_duty1", 32'(duty[15:8]), 32'h40);
        chk("s0_chen", 32'(ch_en), 32'h03);
        idle(8'h01);
        chk("s0_status", 32'(rdata), 32'h02);

        // sync=1 commit waits for period_wrap
        wr(8'h00, 8'h02);
        wr(8'h10, 8'hFF);
        wr(8'h02, 8'h01);
        idle(8'h01);
        idle(8'h01);
        chk("s1_busy", 32'(commit_busy), 32'h1);
        chk("s1_hold", 32'(duty[7:0]), 32'h80);
        cyc(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(8'h01);
        chk("s1_duty0", 32'(duty[7:0]), 32'hFF);
        chk("s1_busy0", 32'(commit_busy), 32'h0);

        // shadow write in the COPY cycle
        wr(8'h00, 8'h00);
        wr(8'h10, 8'h22);
        wr(8'h02, 8'h01);
        wr(8'h10, 8'h33);
        idle(8'h10);
        chk("col_act", 32'(duty[7:0]), 32'h22);
        chk("col_shadow", 32'(rdata), 32'h33);
        wr(8'h02, 8'h01);
        idle(8'h10);
        chk("col_act2", 32'(duty[7:0]), 32'h33);

        // STATUS read-clear, then clear colliding with a copy
        idle(8'h01);
        cyc(1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rc_read", 32'(rdata), 32'h02);
        idle(8'h01);
        chk("rc_cleared", 32'(rdata), 32'h00);
        wr(8'h02, 8'h01);
        cyc(1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(8'h01);
        chk("rc_setwins", 32'(rdata), 32'h02);

        // active-readback address
        idle(8'h20);
        idle(8'h20);
`ifdef LED_REG_ACTIVE_READBACK_EN
        chk("rb_0x20", 32'(rdata), 32'h33);
`else
        chk("rb_0x20", 32'(rdata), 32'h00);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 8'($urandom_range(0, 5));
                1: ra = 8'(16 + $urandom_range(0, NUM_CH - 1));
                2: ra = 8'h02;
                3: ra = 8'(32 + $urandom_range(0, NUM_CH - 1));
                4: ra = 8'($urandom);
                default: ra = 8'h01;
            endcase
            rd   = 8'($urandom);
            rwen = ($urandom_range(0, 2) == 0);
            rrw  = ($urandom_range(0, 1) == 0);
            rru  = ($urandom_range(0, 4) == 0);
            rpw  = ($urandom_range(0, 7) == 0);
            cyc(rwen, ra, rd, rrw, rru, rpw);
        end

        // asynchronous reset while a commit is armed
        wr(8'h00, 8'h03);
        wr(8'h10, 8'h5A);
        wr(8'h02, 8'h01);
        idle(8'h01);
        chk("rst_armed", 32'(commit_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        m_check();
        @(negedge clk);
        rst_n = 1'b1;
        idle(8'h01);
        idle(8'h01);
        chk("rst_status", 32'(rdata), 32'h00);
        chk("rst_duty0", 32'(duty[7:0]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
